// File: rtl/mul_arbiter.sv
// mul_arbiter: two-port arbiter/scheduler for the shared 2-cycle pipelined
// multiplier. Grants at most one request per cycle, keeps consecutive issues
// in the same hi/lo select class, tracks in-flight ops and routes results
// back to the originating port with their tag.
// Optional feature: define MUL_ARB_RR_EN for round-robin priority between the
// two ports; without it req0 always has priority over req1.

package mul_arbiter_pkg;
  typedef enum logic [1:0] {
    MUL_MUL   = 2'd0,
    MUL_MULH  = 2'd1,
    MUL_MULHU = 2'd2
  } mul_opcode_t;
endpackage

module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  mul_opcode_t       req0_opcode,
  input  logic [31:0]       req0_src1,
  input  logic [31:0]       req0_src2,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  mul_opcode_t       req1_opcode,
  input  logic [31:0]       req1_src1,
  input  logic [31:0]       req1_src2,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              mul_valid,
  output mul_opcode_t       mul_opcode,
  output logic [31:0]       mul_src1,
  output logic [31:0]       mul_src2,
  input  logic              mul_ok,
  input  logic [31:0]       mul_result,
  output logic              resp0_valid,
  output logic [TAG_W-1:0]  resp0_tag,
  output logic [31:0]       resp0_result,
  output logic              resp1_valid,
  output logic [TAG_W-1:0]  resp1_tag,
  output logic [31:0]       resp1_result
);

  // class: 0 = lo (MUL), 1 = hi (MULH/MULHU)
  logic             last_v;
  logic             last_cls;
  logic             s1_v, s2_v;
  logic             s1_id, s2_id;
  logic [TAG_W-1:0] s1_tag, s2_tag;
`ifdef MUL_ARB_RR_EN
  logic             rr;
`endif

  logic cls0, cls1, elig0, elig1, gnt0, gnt1, grant, win_id, win_cls;
  logic resp_fire;

  // eligibility (hazard filter) and priority selection
  always_comb begin
    cls0  = (req0_opcode != MUL_MUL);
    cls1  = (req1_opcode != MUL_MUL);
    elig0 = req0_valid && !flush && !reset && !(last_v && (cls0 != last_cls));
    elig1 = req1_valid && !flush && !reset && !(last_v && (cls1 != last_cls));
`ifdef MUL_ARB_RR_EN
    // a blocked preferred port hands the slot to the other eligible port
    gnt0  = elig0 && (!rr || !elig1);
    gnt1  = elig1 && ( rr || !elig0);
`else
    gnt0  = elig0;
    gnt1  = elig1 && !elig0;
`endif
    grant   = gnt0 || gnt1;
    win_id  = gnt1;
    win_cls = gnt1 ? cls1 : cls0;
  end

  // issue port: winner's fields, zero when nothing is granted
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mul_valid  = grant;
    mul_opcode = MUL_MUL;
    mul_src1   = '0;
    mul_src2   = '0;
    if (gnt1) begin
      mul_opcode = req1_opcode;
      mul_src1   = req1_src1;
      mul_src2   = req1_src2;
    end else if (gnt0) begin
      mul_opcode = req0_opcode;
      mul_src1   = req0_src1;
      mul_src2   = req0_src2;
    end
  end

  // in-flight tracking pipe, hazard history and priority pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      last_v   <= 1'b0;
      s1_id    <= 1'b0;
      s2_id    <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      last_cls <= 1'b0;
`ifdef MUL_ARB_RR_EN
      rr       <= 1'b0;
`endif
    end else begin
      // grant is already suppressed during flush, so only s2 needs the kill
      s1_v     <= grant;
      s1_id    <= win_id;
      s1_tag   <= gnt1 ? req1_tag : req0_tag;
      s2_v     <= s1_v && !flush;
      s2_id    <= s1_id;
      s2_tag   <= s1_tag;
      last_v   <= grant;
      last_cls <= win_cls;
`ifdef MUL_ARB_RR_EN
      if (grant) rr <= !win_id;
`endif
    end
  end

  // result routing; a mul_ok with no live s2 entry is a killed op
  always_comb begin
    resp_fire    = mul_ok && s2_v && !reset;
    resp0_valid  = resp_fire && !s2_id;
    resp1_valid  = resp_fire &&  s2_id;
    resp0_tag    = resp0_valid ? s2_tag     : '0;
    resp0_result = resp0_valid ? mul_result : '0;
    resp1_tag    = resp1_valid ? s2_tag     : '0;
    resp1_result = resp1_valid ? mul_result : '0;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed per-cycle vectors with hand-computed
// expected grants and results; a scoreboard queue checked by a monitor.
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int TAG_W = 6;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  mul_opcode_t       req0_opcode, req1_opcode, mul_opcode;
  logic [31:0]       req0_src1, req0_src2, req1_src1, req1_src2;
  logic [TAG_W-1:0]  req0_tag, req1_tag;
  logic              mul_valid, mul_ok;
  logic [31:0]       mul_src1, mul_src2, mul_result;
  logic              resp0_valid, resp1_valid;
  logic [TAG_W-1:0]  resp0_tag, resp1_tag;
  logic [31:0]       resp0_result, resp1_result;

  mul_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .mul_valid(mul_valid), .mul_opcode(mul_opcode), .mul_src1(mul_src1),
    .mul_src2(mul_src2), .mul_ok(mul_ok), .mul_result(mul_result),
    .resp0_valid(resp0_valid), .resp0_tag(resp0_tag), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_tag(resp1_tag), .resp1_result(resp1_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    mul_opcode_t      op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } req_t;

  typedef struct {
    bit               port;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural 2-stage multiplier
  function automatic logic [31:0] mul_model(input mul_opcode_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      MUL_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      MUL_MULH: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[63:32];
      end
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
    endcase
  endfunction

  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_r = '0, p2_r = '0;
  always @(posedge clk) begin
    p1_v <= mul_valid;
    p1_r <= mul_model(mul_opcode, mul_src1, mul_src2);
    p2_v <= p1_v;
    p2_r <= p1_r;
  end
  assign mul_ok     = p2_v;
  assign mul_result = p2_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t rq(input mul_opcode_t op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] t, input logic [31:0] r);
    req_t q;
    q.v = 1'b1; q.op = op; q.a = a; q.b = b; q.tag = t; q.res = r;
    return q;
  endfunction

  function automatic req_t idle();
    req_t q;
    q.v = 1'b0; q.op = MUL_MUL; q.a = '0; q.b = '0; q.tag = '0; q.res = '0;
    return q;
  endfunction

  // one cycle: drive, check grant/issue, push expected responses (dr = killed)
  task automatic step(input bit fl, input bit rs, input req_t r0, input req_t r1,
                      input bit e0, input bit e1, input bit dr);
    req_t w;
    reset = rs; flush = fl;
    req0_valid = r0.v; req0_opcode = r0.op; req0_src1 = r0.a; req0_src2 = r0.b; req0_tag = r0.tag;
    req1_valid = r1.v; req1_opcode = r1.op; req1_src1 = r1.a; req1_src2 = r1.b; req1_tag = r1.tag;
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("mul_valid",  32'(mul_valid),  32'(e0 | e1));
    if (rs) begin
      chk("rst_mul_opcode", 32'(mul_opcode), 32'd0);
      chk("rst_mul_src1", mul_src1, 32'd0);
      chk("rst_mul_src2", mul_src2, 32'd0);
      chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
      chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
      chk("rst_resp0_tag", 32'(resp0_tag), 32'd0);
      chk("rst_resp1_tag", 32'(resp1_tag), 32'd0);
      chk("rst_resp0_result", resp0_result, 32'd0);
      chk("rst_resp1_result", resp1_result, 32'd0);
    end else if (e0 | e1) begin
      w = e1 ? r1 : r0;
      chk("mul_opcode", 32'(mul_opcode), 32'(w.op));
      chk("mul_src1", mul_src1, w.a);
      chk("mul_src2", mul_src2, w.b);
    end
    if (e0 && !dr) sb.push_back('{1'b0, r0.tag, r0.res, cyc + 2});
    if (e1 && !dr) sb.push_back('{1'b1, r1.tag, r1.res, cyc + 2});
    @(posedge clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, idle(), idle(), 1'b0, 1'b0, 1'b0);
  endtask

  // response monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL resp_missing: got no response, want port %0d tag %0d in cycle %0d",
               sb[0].port, sb[0].tag, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (resp0_valid && resp1_valid) begin
      total++; bad++;
      $display("FAIL resp_both: got both valids, want at most one (cycle %0d)", cyc);
    end else if (resp0_valid || resp1_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_spurious: got port %0d tag %0d, want none (cycle %0d)",
                 resp1_valid, resp1_valid ? resp1_tag : resp0_tag, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_port",   32'(resp1_valid), 32'(e.port));
        chk("resp_tag",    32'(resp1_valid ? resp1_tag : resp0_tag), 32'(e.tag));
        chk("resp_result", resp1_valid ? resp1_result : resp0_result, e.res);
        chk("resp_cycle",  cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    step(1'b0, 1'b1, idle(), idle(), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, idle(), idle(), 1'b0, 1'b0, 1'b0);
    nop(1);

    // single op
    step(1'b0, 1'b0, rq(MUL_MUL, 32'h3, 32'hFFFF_FFFF, 6'd5, 32'hFFFF_FFFD), idle(), 1'b1, 1'b0, 1'b0);
    nop(2);

    // class hazard: MULH right after MUL costs one bubble
    step(1'b0, 1'b0, rq(MUL_MUL,  32'h2,         32'h3, 6'd1, 32'h6),         idle(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MULH, 32'h8000_0000, 32'h2, 6'd2, 32'hFFFF_FFFF), idle(), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MULH, 32'h8000_0000, 32'h2, 6'd2, 32'hFFFF_FFFF), idle(), 1'b1, 1'b0, 1'b0);
    nop(3);

    // hazard fallback: req1 (lo) takes the slot while req0 (hi) is blocked
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd5, 32'd7, 6'd3, 32'h23), idle(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'hFFFF_FFFE),
                     rq(MUL_MUL, 32'h1_0001, 32'h1_0001, 6'd5, 32'h0002_0001), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'hFFFF_FFFE), idle(), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'hFFFF_FFFE), idle(), 1'b1, 1'b0, 1'b0);
    nop(3);

    // flush: tag1 delivered in flush cycle, tag2 killed, no grant while flushing
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd4, 32'd5, 6'd1, 32'h14), idle(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd6, 32'd7, 6'd2, 32'h2A), idle(), 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, rq(MUL_MUL, 32'd1, 32'd1, 6'd3, 32'h1),  idle(), 1'b0, 1'b0, 1'b0);
    nop(3);

    // reset one cycle after issue: result dropped
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd9, 32'd9, 6'd7, 32'h51), idle(), 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, rq(MUL_MUL, 32'd1, 32'd2, 6'd8, 32'h2),  idle(), 1'b0, 1'b0, 1'b0);
    nop(2);

    // reset in the cycle the result arrives: outputs stay zero
    step(1'b0, 1'b0, rq(MUL_MUL, 32'hA, 32'hA, 6'd9, 32'h64), idle(), 1'b1, 1'b0, 1'b1);
    nop(1);
    step(1'b0, 1'b1, idle(), idle(), 1'b0, 1'b0, 1'b0);

    // contention directly after reset (priority pointer back to req0)
`ifdef MUL_ARB_RR_EN
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd10, 32'h100, 6'd10, 32'hA00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd11, 32'h100, 6'd11, 32'hB00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd11, 32'h100, 6'd11, 32'hB00),
                     rq(MUL_MUL, 32'd21, 32'h100, 6'd21, 32'h1500), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd12, 32'h100, 6'd12, 32'hC00),
                     rq(MUL_MUL, 32'd21, 32'h100, 6'd21, 32'h1500), 1'b0, 1'b1, 1'b0);
`else
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd10, 32'h100, 6'd10, 32'hA00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd11, 32'h100, 6'd11, 32'hB00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd12, 32'h100, 6'd12, 32'hC00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, rq(MUL_MUL, 32'd13, 32'h100, 6'd13, 32'hD00),
                     rq(MUL_MUL, 32'd20, 32'h100, 6'd20, 32'h1400), 1'b1, 1'b0, 1'b0);
`endif
    nop(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
